// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between IF and ID: a first-word-fall-through FIFO carrying
// instruction, PC and sideband, with an exact occupancy count and an almost_full early warning.
module inst_fetch_queue #(
    parameter int INST_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int META_W    = 1,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INST_W-1:0]        in_inst,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [META_W-1:0]        in_meta,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INST_W-1:0]        out_inst,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [META_W-1:0]        out_meta,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = INST_W + ADDR_W + META_W;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_MARGIN);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] free_slots;
    logic             enq;
    logic             deq;
    logic [ENTRY_W-1:0] head_entry;

    // Handshake readiness is a pure function of the registered count, so no
    // combinational path exists from in_valid/out_ready back to the ready/valid outputs.
    assign in_ready   = (count_q != DEPTH_C);
    assign out_valid  = (count_q != '0);
    assign free_slots = DEPTH_C - count_q;
    assign almost_full = (free_slots <= AF_C);
    assign count      = count_q;

    assign enq = in_valid & in_ready & rdy;
    assign deq = out_valid & out_ready & rdy;

    assign head_entry = mem_q[head_q];
    assign out_inst   = head_entry[ENTRY_W-1 -: INST_W];
    assign out_pc     = head_entry[META_W +: ADDR_W];
    assign out_meta   = head_entry[META_W-1:0];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + 1'b1;
            end
            if (deq) begin
                head_d = head_q + 1'b1;
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately unreset; a flushed or reset write is simply dropped.
    always_ff @(posedge clk) begin
        if (enq && !clear && !rst) begin
            mem_q[tail_q] <= {in_inst, in_pc, in_meta};
        end
    end

endmodule
